hilo_mult_unit: RTL and testbench

//  Multi-cycle multiply unit and HI/LO register file. It is the execute-side responder to the

---
 rtl/hilo_mult_unit_pkg.sv | 18 +
 rtl/hilo_mult_unit_if.sv | 23 ++
 rtl/hilo_mult_unit_mult_shift_add.sv | 48 ++++
 rtl/hilo_mult_unit.sv | 86 ++++++++
 tb/tb_hilo_mult_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/hilo_mult_unit_pkg.sv
// rtl/hilo_mult_unit_pkg.sv - shared widths, FSM encoding and helpers for the HI/LO multiply unit
package hilo_mult_unit_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(WIDTH_DEF);

endpackage

// File: rtl/hilo_mult_unit_if.sv
// rtl/hilo_mult_unit_if.sv - request/result bundle between datapath and the multiply unit
interface hilo_mult_unit_if #(
  parameter int WIDTH = hilo_mult_unit_pkg::WIDTH_DEF
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hisel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hilo_out;

  modport master (
    output start, signed_op, a, b, hisel,
    input  busy, done, hilo_out
  );

  modport slave (
    input  start, signed_op, a, b, hisel,
    output busy, done, hilo_out
  );
endinterface

// File: rtl/hilo_mult_unit_mult_shift_add.sv
// rtl/hilo_mult_unit_mult_shift_add.sv - radix-2 shift-add datapath with iteration counter
module mult_shift_add
  import hilo_mult_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand_in,
  input  logic [WIDTH-1:0]   mult_in,
  output logic [2*WIDTH-1:0] acc,
  output logic               count_zero
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] mult;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   sum;

  // Carry is kept in sum[WIDTH] and shifted into acc_hi, so all-ones operands cannot overflow.
  assign sum        = {1'b0, acc_hi} + (mult[0] ? {1'b0, mcand} : '0);
  assign acc        = {acc_hi, mult};
  assign count_zero = (count == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      acc_hi <= '0;
      mult   <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= mcand_in;
      mult   <= mult_in;
      acc_hi <= '0;
      count  <= CW'(WIDTH);
    end else if (step) begin
      acc_hi <= sum[WIDTH:1];
      mult   <= {sum[0], mult[WIDTH-1:1]};
      count  <= count - CW'(1);
    end
  end

endmodule

// File: rtl/hilo_mult_unit.sv
// rtl/hilo_mult_unit.sv - multi-cycle MULT/MULTU unit with HI/LO registers and mfhi/mflo read mux
module hilo_mult_unit
  import hilo_mult_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  hilo_mult_unit_if.slave    bus
);

  state_t             state;
  logic               busy_r;
  logic               done_r;
  logic               neg;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] product;
  logic               count_zero;
  logic               load;
  logic               step;

  // Magnitude of -2^(W-1) wraps to itself, which is the correct unsigned magnitude.
  assign mag_a   = (bus.signed_op & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign mag_b   = (bus.signed_op & bus.b[WIDTH-1]) ? -bus.b : bus.b;
  assign load    = (state == S_IDLE) & bus.start;
  assign step    = (state == S_RUN) & ~count_zero;
  assign product = neg ? -acc : acc;

  mult_shift_add #(.WIDTH(WIDTH)) u_core (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .mcand_in   (mag_a),
    .mult_in    (mag_b),
    .acc        (acc),
    .count_zero (count_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      neg    <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            neg    <= bus.signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            busy_r <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          // Counter reaches zero on the last step edge; commit on the following edge.
          if (count_zero) begin
            {hi, lo} <= product;
            done_r   <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.hilo_out = bus.hisel ? hi : lo;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// tb/tb_hilo_mult_unit.sv - self-checking bench for hilo_mult_unit
module tb_hilo_mult_unit;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] model_hilo = '0;

  hilo_mult_unit_if #(.WIDTH(W)) bus ();

  hilo_mult_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_hilo(output logic [63:0] v);
    bus.hisel = 1'b1;
    #1 v[63:32] = bus.hilo_out;
    bus.hisel = 1'b0;
    #1 v[31:0] = bus.hilo_out;
  endtask

  function automatic logic [63:0] ref_mult(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    longint sx;
    longint sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic s,
                        input string tag);
    logic [63:0] v;
    int          k;
    bit          held;
    @(negedge clk);
    bus.a = x;
    bus.b = y;
    bus.signed_op = s;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
    k = 0;
    held = 1'b1;
    while (bus.done !== 1'b1 && k < 100) begin
      read_hilo(v);
      if (v !== model_hilo || bus.busy !== 1'b1) held = 1'b0;
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 64'(k), 64'd33);
    chk({tag, "_old_hilo_held"}, 64'(held), 64'd1);
    chk({tag, "_busy_in_done"}, 64'(bus.busy), 64'd1);
    model_hilo = ref_mult(x, y, s);
    read_hilo(v);
    chk({tag, "_result"}, v, model_hilo);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    chk({tag, "_busy_fall"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [63:0] v;
    int          k;
    int          dones;
    bit          held;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    bus.start = 1'b0;
    bus.signed_op = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.hisel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 64'(bus.busy), 64'd0);
    read_hilo(v);
    chk("idle_hilo", v, 64'd0);

    run_op(32'd3, 32'd5, 1'b0, "multu_3x5");
    read_hilo(v);
    chk("multu_3x5_const", v, 64'h00000000_0000000F);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "multu_max");
    read_hilo(v);
    chk("multu_max_const", v, 64'hFFFFFFFE_00000001);
    run_op(32'hFFFFFFFE, 32'd3, 1'b1, "mult_m2x3");
    read_hilo(v);
    chk("mult_m2x3_const", v, 64'hFFFFFFFF_FFFFFFFA);
    run_op(32'h80000000, 32'h80000000, 1'b1, "mult_minmin");
    read_hilo(v);
    chk("mult_minmin_const", v, 64'h40000000_00000000);

    // 7*7 with a restart at cycle 10 and another start held during the done cycle
    @(negedge clk);
    bus.a = 32'd7;
    bus.b = 32'd7;
    bus.signed_op = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    k = 0;
    dones = 0;
    held = 1'b1;
    while (k < 60) begin
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        dones++;
        read_hilo(v);
        chk("restart_lo49", v, 64'd49);
        bus.a = 32'd9;
        bus.b = 32'd9;
        bus.start = 1'b1;
      end else if (dones == 0) begin
        read_hilo(v);
        if (v !== model_hilo) held = 1'b0;
      end
      if (k == 10) begin
        bus.a = 32'd9;
        bus.b = 32'd9;
        bus.start = 1'b1;
      end
      @(negedge clk);
      k++;
    end
    bus.start = 1'b0;
    model_hilo = 64'd49;
    chk("restart_one_done", 64'(dones), 64'd1);
    chk("restart_old_held", 64'(held), 64'd1);
    chk("restart_idle_busy", 64'(bus.busy), 64'd0);
    read_hilo(v);
    chk("restart_final", v, model_hilo);

    // Async reset in the middle of an operation
    run_op(32'd3, 32'd5, 1'b0, "pre_reset");
    @(negedge clk);
    bus.a = 32'd6;
    bus.b = 32'd7;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_done", 64'(bus.done), 64'd0);
    read_hilo(v);
    chk("abort_hilo", v, 64'd0);
    model_hilo = '0;
    @(negedge clk);
    reset = 1'b0;
    run_op(32'd2, 32'd2, 1'b0, "post_reset");
    read_hilo(v);
    chk("post_reset_lo4", v, 64'd4);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      if (i == 0) ra = 32'h80000000;
      if (i == 1) rb = 32'd0;
      run_op(ra, rb, rs, $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
